avalon_bus_arbiter: RTL and testbench

- Two-requester arbiter sharing the single Avalon memory-mapped master bus of the CPU.
- Requester 0 is the instruction-fetch/CPU port; requester 1 is a data/DMA port.
- Grants are registered, and the grant is held until the granted transaction completes.
- Optional waitrequest watchdog flags a hung slave.

---
 rtl/avalon_bus_arbiter.sv | 69 ++++++
 tb/tb_avalon_bus_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter: two-requester Avalon-MM arbiter with parked grants and a waitrequest watchdog
module avalon_bus_arbiter #(
    parameter int ROUND_ROBIN     = 1,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] r0_address,
    input  logic        r0_read,
    input  logic        r0_write,
    input  logic [31:0] r0_writedata,
    input  logic [3:0]  r0_byteenable,
    output logic        r0_waitrequest,
    output logic [31:0] r0_readdata,
    input  logic [31:0] r1_address,
    input  logic        r1_read,
    input  logic        r1_write,
    input  logic [31:0] r1_writedata,
    input  logic [3:0]  r1_byteenable,
    output logic        r1_waitrequest,
    output logic [31:0] r1_readdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        timeout
);
    localparam logic [1:0] IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2;
    logic [1:0]  state, state_next;
    logic        last_grant, req0, req1, mine, other, done;
    logic [15:0] wd_cnt, wd_next;
    assign req0  = r0_read | r0_write;
    assign req1  = r1_read | r1_write;
    assign mine  = state == GNT0 ? req0 : state == GNT1 ? req1 : 1'b0;
    assign other = state == GNT0 ? req1 : req0;
    assign done  = mine & ~waitrequest;
    // Handing over needs an idle owner, or a completed transfer when rotation is allowed
    assign state_next = state == IDLE ?
                            ((req0 & req1) ? ((ROUND_ROBIN != 0 && last_grant) ? GNT0 : GNT1) :
                             req0 ? GNT0 : req1 ? GNT1 : IDLE) :
                        (other && (!mine || (done && (ROUND_ROBIN != 0 || state == GNT0)))) ?
                            (state == GNT0 ? GNT1 : GNT0) : state;
    assign address        = state == GNT0 ? r0_address    : state == GNT1 ? r1_address    : '0;
    assign read           = state == GNT0 ? r0_read       : state == GNT1 ? r1_read       : 1'b0;
    assign write          = state == GNT0 ? r0_write      : state == GNT1 ? r1_write      : 1'b0;
    assign writedata      = state == GNT0 ? r0_writedata  : state == GNT1 ? r1_writedata  : '0;
    assign byteenable     = state == GNT0 ? r0_byteenable : state == GNT1 ? r1_byteenable : '0;
    assign r0_waitrequest = state == GNT0 ? waitrequest : 1'b1;
    assign r1_waitrequest = state == GNT1 ? waitrequest : 1'b1;
    assign r0_readdata    = readdata;
    assign r1_readdata    = readdata;
    assign wd_next = ((read | write) & waitrequest) ? (&wd_cnt ? wd_cnt : wd_cnt + 16'd1) : 16'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= state_next == GNT1 ? 1'b1 : state_next == GNT0 ? 1'b0 : last_grant;
            wd_cnt     <= wd_next;
            timeout    <= timeout | (wd_next >= 16'(WATCHDOG_CYCLES));
        end
    end
endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// tb_avalon_bus_arbiter: round-robin and fixed-priority arbiters against a grant-owner reference model
module tb_avalon_bus_arbiter;
    localparam int WD = 8;
    logic clk = 1'b0, reset = 1'b1;
    logic [31:0] r0_address = '0, r0_writedata = '0, r1_address = '0, r1_writedata = '0, readdata = '0;
    logic r0_read = 1'b0, r0_write = 1'b0, r1_read = 1'b0, r1_write = 1'b0, waitrequest = 1'b0;
    logic [3:0] r0_byteenable = '0, r1_byteenable = '0;
    logic [31:0] a_address, a_writedata, a_r0_readdata, a_r1_readdata;
    logic [31:0] b_address, b_writedata, b_r0_readdata, b_r1_readdata;
    logic a_read, a_write, a_r0_waitrequest, a_r1_waitrequest, a_timeout;
    logic b_read, b_write, b_r0_waitrequest, b_r1_waitrequest, b_timeout;
    logic [3:0] a_byteenable, b_byteenable;
    logic [136:0] obs [2];
    int n_tests = 0, n_fail = 0;
    int own [2] = '{2, 2};
    int last [2] = '{1, 1};
    int cnt [2] = '{0, 0};
    bit to [2] = '{0, 0};
    bit m_q0, m_q1, m_busy;
    int m_n;

    always #5 clk = ~clk;

    avalon_bus_arbiter #(.ROUND_ROBIN(1), .WATCHDOG_CYCLES(WD)) dut_a (
        .clk(clk), .reset(reset),
        .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write), .r0_writedata(r0_writedata),
        .r0_byteenable(r0_byteenable), .r0_waitrequest(a_r0_waitrequest), .r0_readdata(a_r0_readdata),
        .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write), .r1_writedata(r1_writedata),
        .r1_byteenable(r1_byteenable), .r1_waitrequest(a_r1_waitrequest), .r1_readdata(a_r1_readdata),
        .address(a_address), .read(a_read), .write(a_write), .writedata(a_writedata),
        .byteenable(a_byteenable), .waitrequest(waitrequest), .readdata(readdata), .timeout(a_timeout));

    avalon_bus_arbiter #(.ROUND_ROBIN(0), .WATCHDOG_CYCLES(WD)) dut_b (
        .clk(clk), .reset(reset),
        .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write), .r0_writedata(r0_writedata),
        .r0_byteenable(r0_byteenable), .r0_waitrequest(b_r0_waitrequest), .r0_readdata(b_r0_readdata),
        .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write), .r1_writedata(r1_writedata),
        .r1_byteenable(r1_byteenable), .r1_waitrequest(b_r1_waitrequest), .r1_readdata(b_r1_readdata),
        .address(b_address), .read(b_read), .write(b_write), .writedata(b_writedata),
        .byteenable(b_byteenable), .waitrequest(waitrequest), .readdata(readdata), .timeout(b_timeout));

    assign obs[0] = {a_address, a_read, a_write, a_writedata, a_byteenable,
                     a_r0_waitrequest, a_r1_waitrequest, a_timeout, a_r0_readdata, a_r1_readdata};
    assign obs[1] = {b_address, b_read, b_write, b_writedata, b_byteenable,
                     b_r0_waitrequest, b_r1_waitrequest, b_timeout, b_r0_readdata, b_r1_readdata};

    // Owner after this cycle: 2 = nobody, else the requester index holding the bus
    function automatic int next_owner(int o, int l, bit rr, bit q0, bit q1, bit w);
        bit q [2];
        q[0] = q0;
        q[1] = q1;
        if (o == 2) begin
            if (q0 && q1) return rr ? 1 - l : 1;
            return q0 ? 0 : (q1 ? 1 : 2);
        end
        if (!q[1 - o]) return o;
        if (!q[o]) return 1 - o;
        if (!w && (rr || o == 0)) return 1 - o;
        return o;
    endfunction

    function automatic logic [136:0] exp_out(int i);
        logic [69:0] bus;
        logic w0, w1;
        bus = own[i] == 0 ? {r0_address, r0_read, r0_write, r0_writedata, r0_byteenable} :
              own[i] == 1 ? {r1_address, r1_read, r1_write, r1_writedata, r1_byteenable} : 70'd0;
        w0 = own[i] == 0 ? waitrequest : 1'b1;
        w1 = own[i] == 1 ? waitrequest : 1'b1;
        return {bus, w0, w1, to[i], readdata, readdata};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                own[i] = 2; last[i] = 1; cnt[i] = 0; to[i] = 0;
            end else begin
                m_q0 = r0_read | r0_write;
                m_q1 = r1_read | r1_write;
                m_busy = own[i] == 0 ? m_q0 : (own[i] == 1 ? m_q1 : 1'b0);
                cnt[i] = (m_busy && waitrequest) ? (cnt[i] < 65535 ? cnt[i] + 1 : cnt[i]) : 0;
                if (cnt[i] >= WD) to[i] = 1;
                m_n = next_owner(own[i], last[i], i == 0, m_q0, m_q1, waitrequest);
                if (m_n != 2) last[i] = m_n;
                own[i] = m_n;
            end
        end
    end

    task automatic clear_inputs;
        r0_address = '0; r0_read = 0; r0_write = 0; r0_writedata = '0; r0_byteenable = '0;
        r1_address = '0; r1_read = 0; r1_write = 0; r1_writedata = '0; r1_byteenable = '0;
        waitrequest = 0; readdata = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic test_reset;
        reset = 1; r0_read = 1; r1_write = 1; waitrequest = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (obs[i] !== exp_out(i)) begin
                n_fail++;
                $display("FAIL reset_model inst%0d got %h exp %h", i, obs[i], exp_out(i));
            end
        end
        n_tests++;
        if ({a_address, a_read, a_write, a_r0_waitrequest, a_r1_waitrequest, a_timeout,
             b_read, b_write, b_r0_waitrequest, b_r1_waitrequest, b_timeout} !== {32'h0, 5'b00110, 5'b00110}) begin
            n_fail++;
            $display("FAIL reset_idle got addr=%h rd=%b wr=%b w0=%b w1=%b to=%b exp 0/0/0/1/1/0",
                     a_address, a_read, a_write, a_r0_waitrequest, a_r1_waitrequest, a_timeout);
        end
        @(posedge clk);
        #1 reset = 0;
        clear_inputs();
    endtask

    task automatic test_single_read;
        logic [33:0] e;
        do_reset();
        r0_read = 1; r0_address = 32'hBFC00000; waitrequest = 1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin waitrequest = 0; readdata = 32'h12345678; end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs[i] !== exp_out(i)) begin
                    n_fail++;
                    $display("FAIL single_read_model k%0d inst%0d got %h exp %h", k, i, obs[i], exp_out(i));
                end
            end
            e = {k != 3, k > 0, k > 0 ? 32'hBFC00000 : 32'h0};
            n_tests++;
            if ({a_r0_waitrequest, a_read, a_address} !== e || (k == 3 && a_r0_readdata !== 32'h12345678)) begin
                n_fail++;
                $display("FAIL single_read k%0d got w0/rd/addr=%h rdata=%h exp %h", k,
                         {a_r0_waitrequest, a_read, a_address}, a_r0_readdata, e);
            end
            @(posedge clk);
            #1;
        end
        r0_read = 0; readdata = '0;
        @(posedge clk);
        #1 r0_write = 1; r0_address = 32'h20; r0_writedata = 32'h55AA55AA; r0_byteenable = 4'b0011;
        @(negedge clk);
        n_tests++;
        if ({a_write, a_r0_waitrequest, a_address} !== {2'b10, 32'h20}) begin
            n_fail++;
            $display("FAIL parked_r0 got wr=%b w0=%b addr=%h exp 1/0/00000020", a_write, a_r0_waitrequest, a_address);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_contention_rr;
        logic [33:0] e1;
        do_reset();
        r0_read = 1; r0_address = 32'h100;
        r1_write = 1; r1_address = 32'h1000; r1_writedata = 32'hDEADBEEF; r1_byteenable = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs[i] !== exp_out(i)) begin
                    n_fail++;
                    $display("FAIL contention_model k%0d inst%0d got %h exp %h", k, i, obs[i], exp_out(i));
                end
            end
            e1 = (k == 1 || k == 3) ? {2'b10, 32'h100} : (k == 2) ? {2'b01, 32'h1000} : 34'd0;
            n_tests++;
            if ({a_read, a_write, a_address} !== e1 || (k == 2 && {a_writedata, a_byteenable} !== {32'hDEADBEEF, 4'hF})) begin
                n_fail++;
                $display("FAIL contention_rr k%0d got rd/wr/addr=%h wd=%h be=%h exp %h", k,
                         {a_read, a_write, a_address}, a_writedata, a_byteenable, e1);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_fixed_priority;
        do_reset();
        r0_read = 1; r0_address = 32'h300;
        r1_write = 1; r1_address = 32'h1000; r1_writedata = 32'h0BADF00D; r1_byteenable = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs[i] !== exp_out(i)) begin
                    n_fail++;
                    $display("FAIL fixed_model k%0d inst%0d got %h exp %h", k, i, obs[i], exp_out(i));
                end
            end
            n_tests++;
            if ({b_write, b_read, b_r0_waitrequest, b_r1_waitrequest} !== {k > 0, 1'b0, 1'b1, k == 0}) begin
                n_fail++;
                $display("FAIL fixed_priority k%0d got wr/rd/w0/w1=%b%b%b%b", k,
                         b_write, b_read, b_r0_waitrequest, b_r1_waitrequest);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_watchdog;
        do_reset();
        r1_read = 1; r1_address = 32'h40; waitrequest = 1;
        for (int k = 0; k < 13; k++) begin
            if (k == 10) waitrequest = 0;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs[i] !== exp_out(i)) begin
                    n_fail++;
                    $display("FAIL watchdog_model k%0d inst%0d got %h exp %h", k, i, obs[i], exp_out(i));
                end
            end
            n_tests++;
            if ({a_timeout, b_timeout} !== {2{k >= 9}}) begin
                n_fail++;
                $display("FAIL watchdog k%0d got %b%b exp %b", k, a_timeout, b_timeout, k >= 9);
            end
            @(posedge clk);
            #1;
        end
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        n_tests++;
        if ({a_timeout, b_timeout} !== 2'b00) begin
            n_fail++;
            $display("FAIL watchdog_clear got %b%b exp 00", a_timeout, b_timeout);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        do_reset();
        r1_write = 1; r1_address = 32'h2000; waitrequest = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if ({a_write, b_write, a_r1_waitrequest} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_mid_pre got wr=%b%b w1=%b exp 111", a_write, b_write, a_r1_waitrequest);
        end
        @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1 reset = 0; r0_read = 1; r0_address = 32'h3000;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (obs[i] !== exp_out(i)) begin
                n_fail++;
                $display("FAIL reset_mid_model inst%0d got %h exp %h", i, obs[i], exp_out(i));
            end
        end
        n_tests++;
        if ({a_write, a_read, a_r1_waitrequest, a_r0_waitrequest} !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_mid_idle got wr/rd/w1/w0=%b%b%b%b exp 0011",
                     a_write, a_read, a_r1_waitrequest, a_r0_waitrequest);
        end
        waitrequest = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if ({a_read, a_write, a_address, a_r0_waitrequest} !== {2'b10, 32'h3000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_tie got rd/wr=%b%b addr=%h w0=%b exp 10/00003000/0",
                     a_read, a_write, a_address, a_r0_waitrequest);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                r0_read = $urandom_range(0, 2) == 0; r0_write = $urandom_range(0, 3) == 0;
                r0_address = $urandom; r0_writedata = $urandom; r0_byteenable = 4'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                r1_read = $urandom_range(0, 2) == 0; r1_write = $urandom_range(0, 3) == 0;
                r1_address = $urandom; r1_writedata = $urandom; r1_byteenable = 4'($urandom);
            end
            waitrequest = k < 1500 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 15) != 0;
            readdata = $urandom;
            reset = $urandom_range(0, 199) == 0;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs[i] !== exp_out(i)) begin
                    n_fail++;
                    $display("FAIL random k%0d inst%0d got %h exp %h", k, i, obs[i], exp_out(i));
                end
            end
            @(posedge clk);
            #1;
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention_rr();
        test_fixed_priority();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
